// File: rtl/buffered_uart_tx.sv
// FIFO-buffered UART transmitter: 8N1-style framing with optional parity and 1/2 stop bits.
// Define UART_TX_CRC8_EN to append a CRC-8 character after every FRAME_LEN data characters.
module buffered_uart_tx #(
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 512,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int FRAME_LEN    = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [DATA_W-1:0]        din,
  input  logic                     we,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     tx,
  output logic                     tx_active,
  output logic                     frame_done,
  output logic [2:0]               state_dbg
);

  localparam int AW       = $clog2(DEPTH);
  localparam int STOP_LEN = STOP_BITS * CLKS_PER_BIT;
  localparam int CW       = $clog2(STOP_LEN);
  localparam int BW       = $clog2(DATA_W);
  localparam logic [CW-1:0] BIT_LAST     = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] STOP_LAST    = CW'(STOP_LEN - 1);
  localparam logic [BW-1:0] BIT_IDX_LAST = BW'(DATA_W - 1);
  localparam logic          PAR_INV      = (PARITY_MODE == 2);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
`ifdef UART_TX_CRC8_EN
    , S_CRC
`endif
  } state_t;

  // ---------------- FIFO ----------------
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q;
  logic              overflow_q;
  logic              push, pop;
  logic [DATA_W-1:0] fifo_head;

  assign full      = (count_q == (AW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign push      = we && !full;
  assign fifo_head = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      // A full FIFO drops the write even if a pop frees a slot this cycle.
      if (we && full) overflow_q <= 1'b1;
    end
  end

  // ---------------- Transmit FSM ----------------
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              par_q, par_d;
  logic              tx_q, tx_active_q;
  logic              line, launch;
  logic              bit_end, stop_end;

  assign bit_end   = (cnt_q == BIT_LAST);
  assign stop_end  = (cnt_q == STOP_LAST);
  assign state_dbg = state_q;
  assign tx        = tx_q;
  assign tx_active = tx_active_q;

`ifdef UART_TX_CRC8_EN
  localparam int FCW = $clog2(FRAME_LEN + 1);
  logic [7:0]     crc_q, crc_d, crc_base;
  logic [FCW-1:0] frame_cnt_q, frame_cnt_d, frame_base;
  logic           crc_char_q, crc_char_d;
  logic           frame_done_q, frame_done_d;

  function automatic logic [7:0] crc8_next(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  assign frame_done = frame_done_q;
`else
  assign frame_done = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    pop     = 1'b0;
    launch  = 1'b0;
    line    = 1'b1;
`ifdef UART_TX_CRC8_EN
    crc_d        = crc_q;
    frame_cnt_d  = frame_cnt_q;
    crc_char_d   = crc_char_q;
    frame_done_d = 1'b0;
    crc_base     = crc_q;
    frame_base   = frame_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        launch = 1'b1;
      end
      S_START: begin
        line = 1'b0;
        if (bit_end) begin
          cnt_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        line = shreg_q[0];
        if (bit_end) begin
          cnt_d   = '0;
          shreg_d = shreg_q >> 1;
          bit_d   = bit_q + 1'b1;
          if (bit_q == BIT_IDX_LAST) state_d = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        line = par_q;
        if (bit_end) begin
          cnt_d   = '0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (stop_end) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          launch  = 1'b1;
`ifdef UART_TX_CRC8_EN
          // The CRC character closes the frame; the next data byte starts a fresh one.
          if (crc_char_q) begin
            frame_done_d = 1'b1;
            crc_char_d   = 1'b0;
            crc_base     = '0;
            frame_base   = '0;
            crc_d        = '0;
            frame_cnt_d  = '0;
          end
`endif
        end
      end
`ifdef UART_TX_CRC8_EN
      S_CRC: begin
        line = 1'b0;
        if (bit_end) begin
          cnt_d   = '0;
          state_d = S_DATA;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (launch && enable) begin
`ifdef UART_TX_CRC8_EN
      if (frame_base == FCW'(FRAME_LEN)) begin
        shreg_d    = DATA_W'(crc_base);
        par_d      = (^crc_base) ^ PAR_INV;
        crc_char_d = 1'b1;
        state_d    = S_CRC;
        cnt_d      = '0;
        bit_d      = '0;
      end else
`endif
      if (!empty) begin
        pop     = 1'b1;
        shreg_d = fifo_head;
        par_d   = (^fifo_head) ^ PAR_INV;
        state_d = S_START;
        cnt_d   = '0;
        bit_d   = '0;
`ifdef UART_TX_CRC8_EN
        crc_d       = crc8_next(crc_base, 8'(fifo_head));
        frame_cnt_d = frame_base + 1'b1;
`endif
      end
    end
  end

  // Line outputs are registered from the current state, so they trail the FSM by one cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shreg_q     <= '0;
      par_q       <= 1'b0;
      tx_q        <= 1'b1;
      tx_active_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      par_q       <= par_d;
      tx_q        <= line;
      tx_active_q <= (state_q != S_IDLE);
    end
  end

`ifdef UART_TX_CRC8_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      crc_q        <= '0;
      frame_cnt_q  <= '0;
      crc_char_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      crc_q        <= crc_d;
      frame_cnt_q  <= frame_cnt_d;
      crc_char_q   <= crc_char_d;
      frame_done_q <= frame_done_d;
    end
  end
`endif

endmodule
